// File: rtl/hv_timing_gen.sv
// Raster timing generator: free-running horizontal/vertical counters over a full
// frame (active + blanking) with registered sync, data-enable, coordinates and
// line/frame start strobes. Outputs decode the counter values written on the same edge.
module hv_timing_gen #(
    parameter int unsigned busWidth = 12,
    parameter int unsigned hActive  = 1920,
    parameter int unsigned hFront   = 88,
    parameter int unsigned hSyncLen = 44,
    parameter int unsigned hBack    = 148,
    parameter int unsigned vActive  = 1080,
    parameter int unsigned vFront   = 4,
    parameter int unsigned vSyncLen = 5,
    parameter int unsigned vBack    = 36,
    parameter logic        syncPol  = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    output logic                hSync,
    output logic                vSync,
    output logic                dataEnable,
    output logic [busWidth-1:0] pixelX,
    output logic [busWidth-1:0] pixelY,
    output logic                lineStart,
    output logic                frameStart
);

    localparam int unsigned hTotal      = hActive + hFront + hSyncLen + hBack;
    localparam int unsigned vTotal      = vActive + vFront + vSyncLen + vBack;
    localparam int unsigned hSyncStart  = hActive + hFront;
    localparam int unsigned hSyncEnd    = hSyncStart + hSyncLen;
    localparam int unsigned vSyncStart  = vActive + vFront;
    localparam int unsigned vSyncEnd    = vSyncStart + vSyncLen;

    localparam logic [busWidth-1:0] hLast = busWidth'(hTotal - 1);
    localparam logic [busWidth-1:0] vLast = busWidth'(vTotal - 1);

    logic [busWidth-1:0] hCount;
    logic [busWidth-1:0] vCount;
    logic [busWidth-1:0] hNext;
    logic [busWidth-1:0] vNext;
    logic [31:0]         hNextWide;
    logic [31:0]         vNextWide;
    logic                deNext;
    logic                hSyncNext;
    logic                vSyncNext;

    // Next counter position and the decode of that position
    always_comb begin
        hNext = hCount + 1'b1;
        vNext = vCount;
        if (hCount == hLast) begin
            hNext = '0;
            vNext = (vCount == vLast) ? '0 : vCount + 1'b1;
        end
        // Compare at 32 bits so window ends equal to the total never overflow busWidth
        hNextWide = 32'(hNext);
        vNextWide = 32'(vNext);
        deNext    = (hNextWide < hActive) && (vNextWide < vActive);
        hSyncNext = (hNextWide >= hSyncStart) && (hNextWide < hSyncEnd);
        vSyncNext = (vNextWide >= vSyncStart) && (vNextWide < vSyncEnd);
    end

    // Counter and output registers; strobes drop on idle edges so they never repeat
    always_ff @(posedge clock) begin
        if (reset) begin
            hCount     <= hLast;
            vCount     <= vLast;
            hSync      <= ~syncPol;
            vSync      <= ~syncPol;
            dataEnable <= 1'b0;
            pixelX     <= '0;
            pixelY     <= '0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end else if (enable) begin
            hCount     <= hNext;
            vCount     <= vNext;
            hSync      <= hSyncNext ? syncPol : ~syncPol;
            vSync      <= vSyncNext ? syncPol : ~syncPol;
            dataEnable <= deNext;
            pixelX     <= deNext ? hNext : '0;
            pixelY     <= deNext ? vNext : '0;
            lineStart  <= (hNext == '0);
            frameStart <= (hNext == '0) && (vNext == '0);
        end else begin
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hv_timing_gen.sv
// Bench for hv_timing_gen: small-timing instances (both sync polarities) checked
// against a table and an enabled-only reference model, plus a default-timing instance.
module tb_hv_timing_gen;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        ls;
        logic        fs;
    } outs_t;

    typedef struct {
        logic  rst;
        logic  en;
        outs_t exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic sRst = 1'b1, sEn = 1'b0;
    logic bRst = 1'b1, bEn = 1'b0;

    logic        sHs, sVs, sDe, sLs, sFs;
    logic [11:0] sX, sY;
    logic        nHs, nVs, nDe, nLs, nFs;
    logic [11:0] nX, nY;
    logic        bHs, bVs, bDe, bLs, bFs;
    logic [11:0] bX, bY;

    hv_timing_gen #(
        .busWidth(12), .hActive(HA), .hFront(HF), .hSyncLen(HS), .hBack(HB),
        .vActive(VA), .vFront(VF), .vSyncLen(VS), .vBack(VB), .syncPol(1'b1)
    ) dutSmall (
        .clock(clk), .reset(sRst), .enable(sEn), .hSync(sHs), .vSync(sVs),
        .dataEnable(sDe), .pixelX(sX), .pixelY(sY), .lineStart(sLs), .frameStart(sFs)
    );

    hv_timing_gen #(
        .busWidth(12), .hActive(HA), .hFront(HF), .hSyncLen(HS), .hBack(HB),
        .vActive(VA), .vFront(VF), .vSyncLen(VS), .vBack(VB), .syncPol(1'b0)
    ) dutNeg (
        .clock(clk), .reset(sRst), .enable(sEn), .hSync(nHs), .vSync(nVs),
        .dataEnable(nDe), .pixelX(nX), .pixelY(nY), .lineStart(nLs), .frameStart(nFs)
    );

    hv_timing_gen dutBig (
        .clock(clk), .reset(bRst), .enable(bEn), .hSync(bHs), .vSync(bVs),
        .dataEnable(bDe), .pixelX(bX), .pixelY(bY), .lineStart(bLs), .frameStart(bFs)
    );

    int    errors = 0;
    int    checks = 0;
    outs_t expQ[$];
    int    mh, mv;
    outs_t mOut;
    vec_t  vecs[20];

    function automatic outs_t mk(logic hs, logic vs, logic de, int x, int y, logic ls, logic fs);
        outs_t o;
        o.hs = hs; o.vs = vs; o.de = de; o.x = 12'(x); o.y = 12'(y); o.ls = ls; o.fs = fs;
        return o;
    endfunction

    function automatic outs_t packSmall();
        return mk(sHs, sVs, sDe, int'(sX), int'(sY), sLs, sFs);
    endfunction

    // Negative-polarity instance reported in positive terms
    function automatic outs_t packNeg();
        return mk(~nHs, ~nVs, nDe, int'(nX), int'(nY), nLs, nFs);
    endfunction

    function automatic outs_t packBig();
        return mk(bHs, bVs, bDe, int'(bX), int'(bY), bLs, bFs);
    endfunction

    task automatic check(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b, want hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
                     name, $time, act.hs, act.vs, act.de, act.x, act.y, act.ls, act.fs,
                     exp.hs, exp.vs, exp.de, exp.x, exp.y, exp.ls, exp.fs);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // Enabled-only reference model of the small timing
    task automatic modelStep(input logic rst, input logic en);
        if (rst) begin
            mh = HT - 1; mv = VT - 1;
            mOut = '0;
        end else if (en) begin
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            mOut.de = (mh < HA) && (mv < VA);
            mOut.x  = mOut.de ? 12'(mh) : 12'd0;
            mOut.y  = mOut.de ? 12'(mv) : 12'd0;
            mOut.hs = (mh >= HA + HF) && (mh < HA + HF + HS);
            mOut.vs = (mv >= VA + VF) && (mv < VA + VF + VS);
            mOut.ls = (mh == 0);
            mOut.fs = (mh == 0) && (mv == 0);
        end else begin
            mOut.ls = 1'b0;
            mOut.fs = 1'b0;
        end
    endtask

    task automatic step(input logic rst, input logic en, input outs_t exp);
        outs_t e;
        sRst = rst; sEn = en;
        expQ.push_back(exp);
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        check("small", packSmall(), e);
        check("negPol", packNeg(), e);
    endtask

    task automatic modelDrive(input logic rst, input logic en);
        modelStep(rst, en);
        step(rst, en, mOut);
    endtask

    task automatic bstep(input logic rst, input logic en);
        bRst = rst; bEn = en;
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int    lastFs, deCnt, vsCnt, fsSeen, cyc;
        logic  prevLs, prevFs;
        outs_t bExp;

        vecs[0]  = '{1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0)};
        vecs[2]  = '{1'b0, 1'b1, mk(0, 0, 1, 0, 0, 1, 1)};
        vecs[3]  = '{1'b0, 1'b1, mk(0, 0, 1, 1, 0, 0, 0)};
        vecs[4]  = '{1'b0, 1'b0, mk(0, 0, 1, 1, 0, 0, 0)};
        vecs[5]  = '{1'b0, 1'b1, mk(0, 0, 1, 2, 0, 0, 0)};
        vecs[6]  = '{1'b0, 1'b1, mk(0, 0, 1, 3, 0, 0, 0)};
        vecs[7]  = '{1'b0, 1'b1, mk(0, 0, 1, 4, 0, 0, 0)};
        vecs[8]  = '{1'b0, 1'b1, mk(0, 0, 1, 5, 0, 0, 0)};
        vecs[9]  = '{1'b0, 1'b1, mk(0, 0, 1, 6, 0, 0, 0)};
        vecs[10] = '{1'b0, 1'b1, mk(0, 0, 1, 7, 0, 0, 0)};
        vecs[11] = '{1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0)};
        vecs[12] = '{1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0)};
        vecs[13] = '{1'b0, 1'b1, mk(1, 0, 0, 0, 0, 0, 0)};
        vecs[14] = '{1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0)};
        vecs[15] = '{1'b0, 1'b1, mk(1, 0, 0, 0, 0, 0, 0)};
        vecs[16] = '{1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0)};
        vecs[17] = '{1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0)};
        vecs[18] = '{1'b0, 1'b1, mk(0, 0, 1, 0, 1, 1, 0)};
        vecs[19] = '{1'b0, 1'b0, mk(0, 0, 1, 0, 1, 0, 0)};

        for (int i = 0; i < 20; i++) step(vecs[i].rst, vecs[i].en, vecs[i].exp);

        // Constant enable over three frames: period, active count, vsync length
        modelDrive(1'b1, 1'b0);
        lastFs = -1; deCnt = 0; vsCnt = 0; fsSeen = 0;
        for (int c = 0; c < 3 * HT * VT + 1; c++) begin
            modelDrive(1'b0, 1'b1);
            if (sFs) begin
                if (lastFs >= 0) begin
                    checkInt("framePeriod", c - lastFs, HT * VT);
                    checkInt("deCount", deCnt, HA * VA);
                    checkInt("vsCount", vsCnt, HT);
                end
                lastFs = c; deCnt = 0; vsCnt = 0; fsSeen++;
            end
            if (sDe) deCnt++;
            if (sVs) vsCnt++;
        end
        checkInt("frameCount", fsSeen, 4);

        // Random enable against the model; strobes never on two cycles in a row
        prevLs = 1'b0; prevFs = 1'b0;
        for (int c = 0; c < 400; c++) begin
            modelDrive(1'b0, 1'($urandom_range(0, 1)));
            if (prevLs) checkInt("lsRepeat", int'(sLs), 0);
            if (prevFs) checkInt("fsRepeat", int'(sFs), 0);
            prevLs = sLs; prevFs = sFs;
        end

        // Mid-line reset on the small instance, then restart at (0,0)
        for (int c = 0; c < 20; c++) modelDrive(1'b0, 1'b1);
        modelDrive(1'b1, 1'b1);
        modelDrive(1'b0, 1'b0);
        modelDrive(1'b0, 1'b1);
        checkInt("restartFs", int'(sFs), 1);

        // Default 1080p timing: reset, first line including hsync window, line wrap
        bstep(1'b1, 1'b1);
        bstep(1'b1, 1'b1);
        check("bigReset", packBig(), mk(0, 0, 0, 0, 0, 0, 0));
        bstep(1'b0, 1'b1);
        check("bigFirst", packBig(), mk(0, 0, 1, 0, 0, 1, 1));
        for (int k = 1; k < 2200; k++) begin
            bstep(1'b0, 1'b1);
            bExp = mk((k >= 2008) && (k < 2052), 0, k < 1920, (k < 1920) ? k : 0, 0, 0, 0);
            check("bigLine0", packBig(), bExp);
        end
        bstep(1'b0, 1'b1);
        check("bigLine1", packBig(), mk(0, 0, 1, 0, 1, 1, 0));
        for (int k = 1; k <= 500; k++) bstep(1'b0, 1'b1);
        check("bigMid", packBig(), mk(0, 0, 1, 500, 1, 0, 0));
        bstep(1'b1, 1'b1);
        check("bigMidReset", packBig(), mk(0, 0, 0, 0, 0, 0, 0));
        bstep(1'b0, 1'b1);
        check("bigRestart", packBig(), mk(0, 0, 1, 0, 0, 1, 1));
        bstep(1'b0, 1'b0);
        check("bigHold", packBig(), mk(0, 0, 1, 0, 0, 0, 0));
        cyc = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hv_timing_gen.md
# hv_timing_gen

Raster timing generator for the HDMI output path. It sits directly upstream of the vertical sync stage and the overlay pixel logic. It runs horizontal and vertical counters over a full frame, including blanking, and produces horizontal sync, vertical sync, data-enable, the active pixel coordinates, and line and frame start strobes. Timings are set by parameters; the defaults are 1920x1080p60 CEA timing.

## Interface
- busWidth, 12: width of counters and coordinate outputs; must hold both HTOTAL-1 and VTOTAL-1.
- hActive, 1920: active pixels per line.
- hFront, 88: horizontal front porch, in clocks.
- hSyncLen, 44: horizontal sync width, in clocks.
- hBack, 148: horizontal back porch, in clocks.
- vActive, 1080: active lines per frame.
- vFront, 4: vertical front porch, in lines.
- vSyncLen, 5: vertical sync width, in lines.
- vBack, 36: vertical back porch, in lines.
- syncPol, 1'b1: asserted level of hSync and vSync (1 = positive).
- clock  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  pixel advance qualifier; counters step only on edges where enable=1.
- hSync  out  1  horizontal sync, at level syncPol while asserted.
- vSync  out  1  vertical sync, at level syncPol while asserted.
- dataEnable  out  1  high during active pixels.
- pixelX  out  busWidth  active column, 0..hActive-1; 0 outside active.
- pixelY  out  busWidth  active row, 0..vActive-1; 0 outside active.
- lineStart  out  1  one-cycle strobe when hCount becomes 0.
- frameStart  out  1  one-cycle strobe when hCount and vCount both become 0.

## Operation
- Derived constants: HTOTAL = hActive+hFront+hSyncLen+hBack (2200); VTOTAL = vActive+vFront+vSyncLen+vBack (1125).
- hCount runs 0..HTOTAL-1 and wraps to 0. vCount increments only when hCount wraps, runs 0..VTOTAL-1, and wraps to 0.
- Horizontal region order: active [0, hActive), front porch, sync [hActive+hFront, hActive+hFront+hSyncLen), back porch.
- Vertical region order is the same, using the v* parameters.
- On every enabled edge the counters advance. All outputs are registered and reflect the decode of the new counter values in the same edge. There is no extra pipeline lag between counters and outputs.
- dataEnable = (hCount < hActive) && (vCount < vActive).
- pixelX and pixelY carry hCount and vCount while dataEnable=1, and read 0 otherwise.
- hSync asserts for hCount in the sync window, on every line including vertical blanking.
- vSync asserts for vCount in the vertical sync window. Its edges coincide with hCount = 0.
- lineStart is high for the cycle after an enabled edge that produces hCount = 0.
- frameStart is high for the cycle after an enabled edge that produces (0,0). lineStart is also high in that cycle.
- enable = 0:
  - Counters, hSync, vSync, dataEnable, pixelX and pixelY hold their values.
  - lineStart and frameStart clear to 0, so a strobe is never repeated.
- Reset:
  - hCount = HTOTAL-1 and vCount = VTOTAL-1.
  - hSync and vSync at the deasserted level (~syncPol).
  - dataEnable, pixelX, pixelY, lineStart and frameStart are 0.
  - Reset takes priority over enable.
- Reset mid-frame: on the next edge all state returns to reset values, with no partial strobe. The first enabled edge after reset lands on (0,0) and raises frameStart.

## Timing
- Latency from reset release with enable=1: one clock to the first active pixel (dataEnable=1, x=0, y=0, frameStart=1, lineStart=1).
- Line period is HTOTAL enabled clocks; frame period is HTOTAL*VTOTAL enabled clocks (2,475,000 at defaults).
- Default windows:
  - hSync high at hCount 2008..2051.
  - vSync high from line 1084, hCount 0, through the end of line 1088.
  - dataEnable low on hCount ≥ 1920 and on vCount ≥ 1080.
- Line wrap and frame wrap occur in the same edge at (HTOTAL-1, VTOTAL-1). Both strobes fire together in the following cycle.
- No combinational path from any input to any output.

## Test plan
- Reset, then enable=1 constantly with default parameters:
  - First edge gives dataEnable=1, pixelX=0, pixelY=0, frameStart=1.
  - The next frameStart arrives exactly 2,475,000 clocks later.
  - Exactly 1920×1080 dataEnable cycles per frame.
- Small parameter set (hActive 8, hFront 2, hSyncLen 2, hBack 2, vActive 4, vFront 1, vSyncLen 1, vBack 1):
  - hSync high at hCount 10..11.
  - vSync high for all 14 clocks of line 5.
  - pixelX sequence 0..7, then 0 through blanking.
- Toggle enable randomly, about 50% duty:
  - Outputs match an enabled-only reference model.
  - Strobes are never high for two consecutive cycles.
- Set syncPol=0: hSync and vSync idle high and go low only in their windows.
- Assert reset for one cycle mid-line (hCount≈500, vCount≈300):
  - Outputs return to reset values the next cycle.
  - The following enabled edge gives (0,0) with frameStart=1.
- Wrap check at (2199,1124): the next edge gives hCount 0, vCount 0, with lineStart and frameStart both high for exactly one cycle.
